uart_rx: RTL and testbench

//  Serial UART receiver, the peer stage that consumes the transmitter's tx line (8N1, LSB first, idle high).

---
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
// Start detection, mid-bit sampling, framing-error detection and break handling.
// Optional even parity (8E1) when the macro UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_reg, state_next;

    logic              rx_meta_reg, rx_s_reg;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              frame_err_reg, frame_err_next;
    logic              tick, tick_last;
`ifdef UART_RX_PARITY_EN
    logic              par_reg, par_next;
    logic              parity_err_reg, parity_err_next;
`endif

    assign tick      = (div_cnt_reg == DIV_MAX);
    assign tick_last = tick && (tick_cnt_reg == TICK_MAX);

    // Two-flop synchroniser; preset high so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Datapath registers: divider, tick counter, shifter and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg   <= '0;
            tick_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg        <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            div_cnt_reg   <= div_cnt_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_reg        <= par_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Next-state and datapath logic; the divider is re-phased on start detection
    // so every sample lands at the middle of its bit.
    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = tick ? '0 : div_cnt_reg + DIV_ONE;
        tick_cnt_next  = tick_cnt_reg;
        if (tick) tick_cnt_next = (tick_cnt_reg == TICK_MAX) ? '0 : tick_cnt_reg + TICK_ONE;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next        = par_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                tick_cnt_next = '0;
                bit_idx_next  = '0;
                if (!rx_s_reg) begin
                    state_next   = S_START;
                    div_cnt_next = '0;
                end
            end
            S_START: begin
                if (tick && (tick_cnt_reg == TICK_HALF)) begin
                    tick_cnt_next = '0;
                    state_next    = rx_s_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    shift_next[bit_idx_reg] = rx_s_reg;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_last) begin
                    par_next   = rx_s_reg;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_last) begin
                    if (rx_s_reg) begin
                        state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_reg ^ (^shift_reg)) begin
                            parity_err_next = 1'b1;
                        end else begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end
`else
                        data_next  = shift_reg;
                        valid_next = 1'b1;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                tick_cnt_next = '0;
                if (rx_s_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at default parameters (432 clk/bit).
// Optional parity vectors are enabled with UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int BIT = 432;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = 4107 + 432;
`else
    localparam int EXP_LAT = 4107;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         valid_cnt = 0, fe_cnt = 0, pe_cnt = 0, overlap_cnt = 0;
    int         last_valid_cyc = 0;
    logic [7:0] rx_log[$];
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_log.push_back(data);
            last_valid_cyc = cyc;
        end
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (valid && frame_err) overlap_cnt++;
    end

    int total = 0, bad = 0;
    int start_cyc = 0;
    int lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] log_at(input int i);
        return (rx_log.size() > i) ? rx_log[i] : 8'hxx;
    endfunction

    // Drive rx to b for n clocks; entered and left at posedge+1.
    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame; stop_low extends a low stop bit by that many bit times.
    task automatic send_frame(input logic [7:0] b, input bit par_ok, input int stop_low);
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ ~par_ok, BIT);
`else
        if (!par_ok) hold(1'b1, 0);
`endif
        if (stop_low > 0) hold(1'b0, stop_low * BIT);
        hold(1'b1, BIT);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_parity_err", parity_err, 1'b0);
        rst = 1'b0;

        // Idle line produces nothing
        hold(1'b1, 10000);
        chk("idle_valid_cnt", valid_cnt, 0);
        chk("idle_fe_cnt", fe_cnt, 0);
        chk("idle_busy", busy, 1'b0);

        // Single frame 0xA5 with latency
        send_frame(8'hA5, 1'b1, 0);
        chk("a5_count", valid_cnt, 1);
        chk("a5_data", data, 8'hA5);
        lat = last_valid_cyc - start_cyc;
        chk("a5_latency", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat, EXP_LAT);

        // Back-to-back frames
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h3C, 1'b1, 0);
        chk("b2b_count", valid_cnt, 4);
        chk("b2b_byte0", log_at(1), 8'h00);
        chk("b2b_byte1", log_at(2), 8'hFF);
        chk("b2b_byte2", log_at(3), 8'h3C);
        chk("b2b_data", data, 8'h3C);

        // Start-bit glitch rejection
        hold(1'b0, 100);
        hold(1'b1, 120);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_valid_cnt", valid_cnt, 4);
        chk("glitch_fe_cnt", fe_cnt, 0);

        // Framing error with long low stop, then recovery
        send_frame(8'h55, 1'b1, 3);
        chk("fe_count", fe_cnt, 1);
        chk("fe_valid_cnt", valid_cnt, 4);
        chk("fe_data_hold", data, 8'h3C);
        hold(1'b1, BIT);
        send_frame(8'h12, 1'b1, 0);
        chk("after_fe_count", valid_cnt, 5);
        chk("after_fe_data", data, 8'h12);
        chk("after_fe_fe_cnt", fe_cnt, 1);

        // Reset mid-DATA of 0x81 (start, bits 0..2), then abort
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b0, BIT);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        hold(1'b1, 10 * BIT);
        chk("midrst_valid_cnt", valid_cnt, 5);
        chk("midrst_fe_cnt", fe_cnt, 1);
        chk("midrst_busy_late", busy, 1'b0);
        send_frame(8'h7E, 1'b1, 0);
        chk("after_rst_count", valid_cnt, 6);
        chk("after_rst_data", data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        // Bad parity, good stop
        send_frame(8'h7E, 1'b0, 0);
        chk("par_err_cnt", pe_cnt, 1);
        chk("par_valid_cnt", valid_cnt, 6);
        chk("par_fe_cnt", fe_cnt, 1);
`else
        chk("no_parity_err", pe_cnt, 0);
`endif
        chk("valid_fe_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
